// File: rtl/rtc_bus_sequencer.sv
// Self-timed RTC multiplexed-bus sequencer: runs read bursts (command, then every
// listed register into a coherent snapshot) and write bursts (every register, then commit).
module rtc_bus_sequencer #(
  parameter int                    NUM_REGS  = 9,
  parameter logic [8*NUM_REGS-1:0] REG_ADDRS = 72'h43_42_41_26_25_24_23_22_21,
  parameter int                    PHASE_CYC = 1,
  parameter logic [7:0]            RD_CMD    = 8'hF0,
  parameter logic [7:0]            WR_CMD    = 8'hF1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    wr_mode,
  input  logic [8*NUM_REGS-1:0]   wdata,
  input  logic [7:0]              Dato,
  output logic [8*NUM_REGS-1:0]   rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    AD,
  output logic                    CS,
  output logic                    RD,
  output logic                    WR,
  output logic                    Dir_Dat,
  output logic [7:0]              Direccion
);

  localparam int IW = $clog2(NUM_REGS + 1);
  localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_REGS);
  localparam logic [3:0]    PH_LAST   = 4'(PHASE_CYC - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_A0   = 3'd1;
  localparam logic [2:0] S_A1   = 3'd2;
  localparam logic [2:0] S_A2   = 3'd3;
  localparam logic [2:0] S_D0   = 3'd4;
  localparam logic [2:0] S_D1   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]            state_reg, state_next;
  logic [3:0]            phase_reg, phase_next;
  logic [IW-1:0]         slot_reg, slot_next;
  logic                  mode_reg, mode_next;
  logic [8*NUM_REGS-1:0] wdata_reg;
  logic [8*NUM_REGS-1:0] shadow_reg, shadow_next;
  logic [8*NUM_REGS-1:0] rdata_reg;
  logic                  busy_reg, done_reg;
  logic                  ad_reg, cs_reg, rd_reg, wr_reg, dir_reg;
  logic [7:0]            addr_reg;
  logic                  busy_next, done_next;
  logic                  ad_next, cs_next, rd_next, wr_next, dir_next;
  logic [7:0]            addr_next;

  logic                  accept, phase_last, capture, finishing;
  logic [7:0]            slot_addr, slot_wbyte;

  // Per-slot lookup tables: read bursts lead with the command, write bursts end with it.
  logic [7:0] rd_addr_tab [0:NUM_REGS];
  logic [7:0] wr_addr_tab [0:NUM_REGS];
  logic [7:0] wr_data_tab [0:NUM_REGS];

  assign rd_addr_tab[0]        = RD_CMD;
  assign wr_addr_tab[NUM_REGS] = WR_CMD;
  assign wr_data_tab[NUM_REGS] = 8'h00;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      assign rd_addr_tab[gi+1] = REG_ADDRS[8*gi +: 8];
      assign wr_addr_tab[gi]   = REG_ADDRS[8*gi +: 8];
      assign wr_data_tab[gi]   = wdata_reg[8*gi +: 8];
      assign shadow_next[8*gi +: 8] = (capture && slot_reg == IW'(gi + 1)) ?
                                      Dato : shadow_reg[8*gi +: 8];
    end
  endgenerate

  assign accept     = (state_reg == S_IDLE) && start;
  assign phase_last = (phase_reg == PH_LAST);
  assign capture    = (state_reg == S_D1) && phase_last && !mode_reg;
  assign finishing  = (state_reg == S_D1) && phase_last && (slot_reg == LAST_SLOT);
  assign mode_next  = accept ? wr_mode : mode_reg;

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    slot_next  = slot_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_A0;
          phase_next = 4'd0;
          slot_next  = '0;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: begin
        if (phase_last) begin
          phase_next = 4'd0;
          case (state_reg)
            S_A0:    state_next = S_A1;
            S_A1:    state_next = S_A2;
            S_A2:    state_next = S_D0;
            S_D0:    state_next = S_D1;
            default: begin
              if (slot_reg == LAST_SLOT) begin
                state_next = S_DONE;
              end else begin
                slot_next  = slot_reg + IW'(1);
                state_next = S_A0;
              end
            end
          endcase
        end else begin
          phase_next = phase_reg + 4'd1;
        end
      end
    endcase
  end

  assign slot_addr  = mode_next ? wr_addr_tab[slot_next] : rd_addr_tab[slot_next];
  assign slot_wbyte = wr_data_tab[slot_next];

  // Bus values are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    ad_next   = 1'b1;
    cs_next   = 1'b1;
    rd_next   = 1'b1;
    wr_next   = 1'b1;
    dir_next  = 1'b0;
    addr_next = 8'h00;
    busy_next = 1'b1;
    done_next = 1'b0;
    case (state_next)
      S_A0: ad_next = 1'b0;
      S_A1: begin
        ad_next   = 1'b0;
        cs_next   = 1'b0;
        wr_next   = 1'b0;
        addr_next = slot_addr;
      end
      S_A2: addr_next = slot_addr;
      S_D0, S_D1: begin
        cs_next = 1'b0;
        if (mode_next) begin
          wr_next   = 1'b0;
          addr_next = slot_wbyte;
        end else begin
          rd_next  = 1'b0;
          dir_next = 1'b1;
        end
      end
      S_DONE: begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
      default: busy_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      phase_reg  <= 4'd0;
      slot_reg   <= '0;
      mode_reg   <= 1'b0;
      wdata_reg  <= '0;
      shadow_reg <= '0;
      rdata_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      ad_reg     <= 1'b1;
      cs_reg     <= 1'b1;
      rd_reg     <= 1'b1;
      wr_reg     <= 1'b1;
      dir_reg    <= 1'b0;
      addr_reg   <= 8'h00;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      slot_reg   <= slot_next;
      mode_reg   <= mode_next;
      shadow_reg <= shadow_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      ad_reg     <= ad_next;
      cs_reg     <= cs_next;
      rd_reg     <= rd_next;
      wr_reg     <= wr_next;
      dir_reg    <= dir_next;
      addr_reg   <= addr_next;
      if (accept) begin
        wdata_reg <= wdata;
      end
      // Snapshot includes the byte sampled on this same final edge.
      if (finishing && !mode_reg) begin
        rdata_reg <= shadow_next;
      end
    end
  end

  assign rdata     = rdata_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign AD        = ad_reg;
  assign CS        = cs_reg;
  assign RD        = rd_reg;
  assign WR        = wr_reg;
  assign Dir_Dat   = dir_reg;
  assign Direccion = addr_reg;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Randomized bench for rtc_bus_sequencer: two instances (defaults, and 2 regs x 3-clock phases)
// checked cycle by cycle against a burst timeline computed from slot/phase arithmetic.
module tb_rtc_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2, wr_mode;
  logic [71:0] wdata1;
  logic [15:0] wdata2;
  logic [7:0]  Dato;

  logic [71:0] rdata1;
  logic [15:0] rdata2;
  logic        busy1, done1, ad1, cs1, rd1, wr1, dir1;
  logic        busy2, done2, ad2, cs2, rd2, wr2, dir2;
  logic [7:0]  dir_addr1, dir_addr2;

  always #5 clk = ~clk;

  rtc_bus_sequencer u1 (
    .clk(clk), .rst(rst), .start(start1), .wr_mode(wr_mode), .wdata(wdata1), .Dato(Dato),
    .rdata(rdata1), .busy(busy1), .done(done1), .AD(ad1), .CS(cs1), .RD(rd1), .WR(wr1),
    .Dir_Dat(dir1), .Direccion(dir_addr1)
  );

  rtc_bus_sequencer #(.NUM_REGS(2), .REG_ADDRS(16'h3412), .PHASE_CYC(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .wr_mode(wr_mode), .wdata(wdata2), .Dato(Dato),
    .rdata(rdata2), .busy(busy2), .done(done2), .AD(ad2), .CS(cs2), .RD(rd2), .WR(wr2),
    .Dir_Dat(dir2), .Direccion(dir_addr2)
  );

  bit          sel;
  logic [14:0] obs_bus;
  logic [71:0] obs_rdata;
  assign obs_bus   = sel ? {ad2, cs2, rd2, wr2, dir2, dir_addr2, busy2, done2}
                         : {ad1, cs1, rd1, wr1, dir1, dir_addr1, busy1, done1};
  assign obs_rdata = sel ? {56'h0, rdata2} : rdata1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [71:0] model1 = '0;
  logic [15:0] model2 = '0;
  logic [7:0]  tab1 [0:8];
  logic [7:0]  tab2 [0:1];

  localparam logic [14:0] BUS_IDLE = {4'b1111, 1'b0, 8'h00, 1'b0, 1'b0};
  localparam logic [14:0] BUS_DONE = {4'b1111, 1'b0, 8'h00, 1'b0, 1'b1};

  function automatic logic [7:0] reg_addr(bit s, int i);
    return s ? tab2[i] : tab1[i];
  endfunction

  function automatic logic [7:0] slot_addr(bit s, bit mode, int slot);
    int n = s ? 2 : 9;
    if (!mode) return (slot == 0) ? 8'hF0 : reg_addr(s, slot - 1);
    return (slot == n) ? 8'hF1 : reg_addr(s, slot);
  endfunction

  // Expected {AD,CS,RD,WR,Dir_Dat,Direccion,busy,done} c clocks after the accept edge.
  function automatic logic [14:0] exp_bus(bit s, bit mode, int c, logic [71:0] wv);
    int n = s ? 2 : 9;
    int p = s ? 3 : 1;
    int ph = (c / p) % 5;
    int slot = c / (5 * p);
    logic [7:0] a = slot_addr(s, mode, slot);
    logic [7:0] wb = (slot < n) ? wv[8*slot +: 8] : 8'h00;
    case (ph)
      0:       return {4'b0111, 1'b0, 8'h00, 1'b1, 1'b0};
      1:       return {4'b0010, 1'b0, a, 1'b1, 1'b0};
      2:       return {4'b1111, 1'b0, a, 1'b1, 1'b0};
      default: return mode ? {4'b1010, 1'b0, wb, 1'b1, 1'b0}
                           : {4'b1001, 1'b1, 8'h00, 1'b1, 1'b0};
    endcase
  endfunction

  task automatic set_start(bit s, logic v);
    if (s) start2 = v;
    else   start1 = v;
  endtask

  // One burst; entered and left at #1 after a rising edge. RTC returns addr+key on reads,
  // and holds garbage on Dato except right before the final D1 edge of each slot.
  task automatic run_burst(bit s, bit mode, logic [7:0] key, bit keep_start, bit poke);
    int n = s ? 2 : 9;
    int p = s ? 3 : 1;
    int total = 5 * p * (n + 1);
    logic [71:0] wv = '0;
    logic [71:0] old_rd, new_rd;
    int bad0 = n_bad;
    sel = s;
    for (int i = 0; i < n; i++) wv[8*i +: 8] = 8'(key + 8'(i));
    old_rd = s ? {56'h0, model2} : model1;
    new_rd = old_rd;
    if (!mode) begin
      new_rd = '0;
      for (int i = 0; i < n; i++) new_rd[8*i +: 8] = 8'(reg_addr(s, i) + key);
    end
    wdata1  = wv;
    wdata2  = wv[15:0];
    wr_mode = mode;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    wdata1 = 72'({$urandom, $urandom, $urandom});
    wdata2 = 16'($urandom);
    if (!keep_start) set_start(s, 1'b0);
    for (int c = 0; c < total; c++) begin
      logic [14:0] e = exp_bus(s, mode, c, wv);
      n_cmp++;
      if (obs_bus !== e) begin
        n_bad++;
        $display("FAIL bus dut%0d c=%0d got %h want %h", s + 1, c, obs_bus, e);
      end
      n_cmp++;
      if (obs_rdata !== old_rd) begin
        n_bad++;
        $display("FAIL rdata_mid dut%0d c=%0d got %h want %h", s + 1, c, obs_rdata, old_rd);
      end
      if (!mode && (c / p) % 5 == 4 && c % p == p - 1) Dato = 8'(slot_addr(s, 0, c / (5 * p)) + key);
      else Dato = 8'($urandom);
      if (poke) begin
        set_start(s, 1'($urandom));
        wr_mode = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (obs_bus !== BUS_DONE) begin
      n_bad++;
      $display("FAIL done_edge dut%0d got %h want %h", s + 1, obs_bus, BUS_DONE);
    end
    n_cmp++;
    if (obs_rdata !== new_rd) begin
      n_bad++;
      $display("FAIL rdata_done dut%0d got %h want %h", s + 1, obs_rdata, new_rd);
    end
    if (s) model2 = new_rd[15:0];
    else   model1 = new_rd;
    set_start(s, keep_start);
    @(posedge clk); #1;
    n_cmp++;
    if (obs_bus !== BUS_IDLE) begin
      n_bad++;
      $display("FAIL idle_after dut%0d got %h want %h", s + 1, obs_bus, BUS_IDLE);
    end
    $display("burst dut%0d %s key=%02h clocks=%0d poke=%0d keep=%0d errors=%0d",
             s + 1, mode ? "write" : "read ", key, total, poke, keep_start, n_bad - bad0);
  endtask

  task automatic test_reset;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; wr_mode = 1'b0;
    wdata1 = '0; wdata2 = '0; Dato = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    sel = 0;
    n_cmp++;
    if (obs_bus !== BUS_IDLE || rdata1 !== 72'h0) begin
      n_bad++;
      $display("FAIL reset_state got %h/%h want %h/0", obs_bus, rdata1, BUS_IDLE);
    end
    rst = 1'b0;
    // Start a read and drop reset into the A1 phase of slot 3.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (obs_bus !== {4'b0010, 1'b0, 8'h23, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL pre_reset_a1 got %h want %h", obs_bus, {4'b0010, 1'b0, 8'h23, 1'b1, 1'b0});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs_bus !== BUS_IDLE || rdata1 !== 72'h0) begin
      n_bad++;
      $display("FAIL async_reset got %h/%h want %h/0", obs_bus, rdata1, BUS_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs_bus !== BUS_IDLE) begin
      n_bad++;
      $display("FAIL post_reset_idle got %h want %h", obs_bus, BUS_IDLE);
    end
    $display("reset scenario done");
  endtask

  task automatic test_read_default;
    run_burst(0, 0, 8'h01, 0, 0);
    n_cmp++;
    if (rdata1[7:0] !== 8'h22 || rdata1[71:64] !== 8'h44) begin
      n_bad++;
      $display("FAIL read_ends got %h..%h want 44..22", rdata1[71:64], rdata1[7:0]);
    end
  endtask

  task automatic test_write;
    run_burst(0, 1, 8'hA0, 0, 0);
    run_burst(0, 1, 8'($urandom), 0, 0);
  endtask

  task automatic test_slow_phase;
    run_burst(1, 0, 8'($urandom), 0, 0);
    run_burst(1, 1, 8'($urandom), 0, 0);
    run_burst(1, 0, 8'($urandom), 0, 0);
  endtask

  task automatic test_back_to_back;
    run_burst(0, 0, 8'($urandom), 1, 0);
    run_burst(0, 1, 8'($urandom), 1, 0);
    run_burst(0, 0, 8'($urandom), 0, 0);
    run_burst(1, 0, 8'($urandom), 1, 0);
    run_burst(1, 0, 8'($urandom), 0, 0);
  endtask

  task automatic test_start_while_busy;
    run_burst(0, 0, 8'($urandom), 0, 1);
    run_burst(0, 1, 8'($urandom), 0, 1);
    run_burst(1, 0, 8'($urandom), 0, 1);
  endtask

  task automatic test_mixed_sequence;
    run_burst(0, 0, 8'h10, 0, 0);
    run_burst(0, 1, 8'h5A, 0, 0);
    run_burst(0, 0, 8'h77, 0, 0);
    for (int i = 0; i < 4; i++) run_burst(1'($urandom), 1'($urandom), 8'($urandom), 0, 1'($urandom));
  endtask

  initial begin
    tab1[0] = 8'h21; tab1[1] = 8'h22; tab1[2] = 8'h23; tab1[3] = 8'h24; tab1[4] = 8'h25;
    tab1[5] = 8'h26; tab1[6] = 8'h41; tab1[7] = 8'h42; tab1[8] = 8'h43;
    tab2[0] = 8'h12; tab2[1] = 8'h34;
    test_reset;
    test_read_default;
    test_write;
    test_slow_phase;
    test_back_to_back;
    test_start_while_busy;
    test_mixed_sequence;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
